// File: rtl/next_address_pkg.sv
// Shared types for the next-address unit: address width, FSM states and the
// per-cycle action chosen by the priority select.
package next_address_pkg;

  localparam int ADDR_W = 3;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_RET,
    ACT_RET_UF,
    ACT_CALL,
    ACT_CALL_OF,
    ACT_BRANCH,
    ACT_INC
  } action_e;

  // Program counter increment; wraps 7 -> 0 by truncation to ADDR_W bits.
  function automatic addr_t addr_inc(input addr_t a);
    return a + addr_t'(1);
  endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO return-address stack with an occupancy pointer 0..DEPTH.
// Full/empty and the top entry come straight from registered state.
module return_stack
  import next_address_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  ptr;
  logic [ADDR_W-1:0] entries [DEPTH];
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  assign wr_idx = ptr[IDX_W-1:0];
  assign rd_idx = wr_idx - IDX_W'(1);
  assign full   = (ptr == PTR_W'(DEPTH));
  assign empty  = (ptr == '0);
  // Meaningless while empty; the caller never selects it in that case.
  assign top    = entries[rd_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (push && !full) begin
      entries[wr_idx] <= push_data;
      ptr             <= ptr + PTR_W'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PTR_W'(1);
    end
  end

endmodule

// File: rtl/next_address_unit.sv
// Next program-counter select: RUN/HALT FSM, fixed-priority action select,
// modulo-8 incrementer and a return-address stack for call/ret.
module next_address_unit
  import next_address_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Address,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              call,
  input  logic              ret,
  input  logic              halt,
  input  logic              resume,
  output logic [ADDR_W-1:0] nextAddress,
  output logic              halted,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              overflow_err,
  output logic              underflow_err
);

  state_e            state;
  action_e           act;
  logic [ADDR_W-1:0] addr_plus1;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_full;
  logic              stk_empty;
  logic              stk_push;
  logic              stk_pop;

  assign addr_plus1 = addr_inc(Address);

  // ret outranks call, so a simultaneous call is dropped without push or error.
  always_comb begin
    act = ACT_INC;
    if (state == ST_HALT || halt || stall) begin
      act = ACT_HOLD;
    end else if (ret) begin
      act = stk_empty ? ACT_RET_UF : ACT_RET;
    end else if (call) begin
      act = stk_full ? ACT_CALL_OF : ACT_CALL;
    end else if (branch_taken) begin
      act = ACT_BRANCH;
    end
  end

  always_comb begin
    nextAddress = '0;
    if (reset) begin
      case (act)
        ACT_HOLD:   nextAddress = Address;
        ACT_RET:    nextAddress = stk_top;
        ACT_CALL:   nextAddress = branch_target;
        ACT_BRANCH: nextAddress = branch_target;
        default:    nextAddress = addr_plus1;
      endcase
    end
  end

  assign stk_push = (act == ACT_CALL);
  assign stk_pop  = (act == ACT_RET);

  return_stack #(
    .DEPTH(DEPTH)
  ) u_return_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (addr_plus1),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  assign stack_full  = stk_full;
  assign stack_empty = stk_empty;

  // halted is registered alongside the state so it tracks HALT exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_RUN;
      halted        <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (halt) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end
        end
        ST_HALT: begin
          if (resume && !halt) begin
            state  <= ST_RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= ST_RUN;
          halted <= 1'b0;
        end
      endcase
      if (act == ACT_CALL_OF) overflow_err  <= 1'b1;
      if (act == ACT_RET_UF)  underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_next_address_unit.sv
// Randomised bench for next_address_unit against a queue-based behavioural model,
// plus directed scenarios for wrap, call/ret, overflow, underflow, halt and reset.
module tb_next_address_unit;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic [2:0] Address;
  logic       stall;
  logic       branch_taken;
  logic [2:0] branch_target;
  logic       call;
  logic       ret;
  logic       halt;
  logic       resume;
  logic [2:0] nextAddress;
  logic       halted;
  logic       stack_full;
  logic       stack_empty;
  logic       overflow_err;
  logic       underflow_err;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int q[$];
  bit m_halted;
  bit m_of;
  bit m_uf;
  int pc_pred;

  next_address_unit #(
    .DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Address       (Address),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .call          (call),
    .ret           (ret),
    .halt          (halt),
    .resume        (resume),
    .nextAddress   (nextAddress),
    .halted        (halted),
    .stack_full    (stack_full),
    .stack_empty   (stack_empty),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_next();
    int a  = int'(Address);
    int a1 = (a + 1) % 8;
    if (m_halted || halt || stall) return a;
    if (ret)          return (q.size() > 0) ? q[$] : a1;
    if (call)         return (q.size() < DEPTH) ? int'(branch_target) : a1;
    if (branch_taken) return int'(branch_target);
    return a1;
  endfunction

  function automatic void model_update();
    int a1 = (int'(Address) + 1) % 8;
    if (m_halted) begin
      if (resume && !halt) m_halted = 1'b0;
    end else if (halt) begin
      m_halted = 1'b1;
    end else if (!stall) begin
      if (ret) begin
        if (q.size() > 0) void'(q.pop_back());
        else m_uf = 1'b1;
      end else if (call) begin
        if (q.size() < DEPTH) q.push_back(a1);
        else m_of = 1'b1;
      end
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    m_halted = 1'b0;
    m_of     = 1'b0;
    m_uf     = 1'b0;
  endfunction

  task automatic apply(input logic [2:0] a, input logic st, input logic br,
                       input logic [2:0] bt, input logic ca, input logic re,
                       input logic ha, input logic rs);
    @(negedge clk);
    Address       = a;
    stall         = st;
    branch_taken  = br;
    branch_target = bt;
    call          = ca;
    ret           = re;
    halt          = ha;
    resume        = rs;
    #1;
  endtask

  // Compare every output against the model, then commit the model across the edge.
  task automatic advance();
    int e = model_next();
    check("nextAddress", 32'(nextAddress), 32'(e));
    check("halted", 32'(halted), 32'(m_halted));
    check("stack_full", 32'(stack_full), 32'(q.size() == DEPTH));
    check("stack_empty", 32'(stack_empty), 32'(q.size() == 0));
    check("overflow_err", 32'(overflow_err), 32'(m_of));
    check("underflow_err", 32'(underflow_err), 32'(m_uf));
    pc_pred = e;
    model_update();
    @(posedge clk);
  endtask

  task automatic idle(input logic [2:0] a);
    apply(a, 0, 0, 3'd0, 0, 0, 0, 0);
  endtask

  // Assert reset between edges with random controls applied; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_next", 32'(nextAddress), 32'd0);
    check("rst_empty", 32'(stack_empty), 32'd1);
    check("rst_full", 32'(stack_full), 32'd0);
    check("rst_of", 32'(overflow_err), 32'd0);
    check("rst_uf", 32'(underflow_err), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    Address       = 3'($urandom_range(0, 7));
    branch_target = 3'($urandom_range(0, 7));
    {stall, branch_taken, call, ret, halt, resume} = 6'($urandom_range(0, 63));
    #1;
    check("rst_next_ctl", 32'(nextAddress), 32'd0);
    @(negedge clk);
    {stall, branch_taken, call, ret, halt, resume} = 6'd0;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    {stall, branch_taken, call, ret, halt, resume} = 6'd0;
    Address = 3'd0;
    branch_target = 3'd0;
    model_reset();
    pc_pred = 0;

    do_reset();

    // Wrap behaviour right after reset release
    idle(3'd5);
    check("rel_at5", 32'(nextAddress), 32'd6);
    advance();
    idle(3'd7);
    check("rel_at7", 32'(nextAddress), 32'd0);
    advance();

    // call then ret
    apply(3'd2, 0, 0, 3'd6, 1, 0, 0, 0);
    check("call_tgt", 32'(nextAddress), 32'd6);
    advance();
    apply(3'd6, 0, 0, 3'd0, 0, 1, 0, 0);
    check("ret_addr", 32'(nextAddress), 32'd3);
    advance();
    idle(3'd3);
    check("ret_empty", 32'(stack_empty), 32'd1);
    advance();

    // Five calls into a depth-4 stack
    for (int i = 0; i < 5; i++) begin
      apply(3'(i), 0, 0, 3'(i + 3), 1, 0, 0, 0);
      if (i == 4) check("call_full_next", 32'(nextAddress), 32'd5);
      advance();
    end
    idle(3'd1);
    check("of_flag", 32'(overflow_err), 32'd1);
    check("of_full", 32'(stack_full), 32'd1);
    advance();

    // Underflow is sticky
    do_reset();
    apply(3'd4, 0, 0, 3'd0, 0, 1, 0, 0);
    check("uf_next", 32'(nextAddress), 32'd5);
    advance();
    for (int i = 0; i < 10; i++) begin
      idle(3'(i));
      advance();
    end
    idle(3'd0);
    check("uf_sticky", 32'(underflow_err), 32'd1);
    advance();

    // Halt ignores branch/call, resume returns to RUN
    apply(3'd3, 0, 0, 3'd0, 0, 0, 1, 0);
    check("halt_next", 32'(nextAddress), 32'd3);
    advance();
    apply(3'd3, 0, 1, 3'd6, 1, 0, 0, 0);
    check("halted_set", 32'(halted), 32'd1);
    check("halt_hold", 32'(nextAddress), 32'd3);
    advance();
    apply(3'd3, 0, 0, 3'd6, 1, 0, 0, 0);
    advance();
    apply(3'd3, 0, 1, 3'd1, 0, 0, 0, 1);
    advance();
    idle(3'd3);
    check("resume_next", 32'(nextAddress), 32'd4);
    advance();

    // Two pushes then mid-cycle reset
    apply(3'd1, 0, 0, 3'd5, 1, 0, 0, 0);
    advance();
    apply(3'd5, 0, 0, 3'd2, 1, 0, 0, 0);
    advance();
    do_reset();

    // Randomised run; the bench acts as the PC register most of the time
    for (int n = 0; n < 600; n++) begin
      logic [2:0] a;
      if (n > 0 && $urandom_range(0, 59) == 0) do_reset();
      a = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'(pc_pred);
      apply(a,
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 2) == 0),
            3'($urandom_range(0, 7)),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 2) == 0));
      advance();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
